// File: rtl/rx_data_reg_pkg.sv
// ============================================================================
// Module   : rx_data_reg_pkg
// Brief    : Shared USRT constants and the occupancy-width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rx_data_reg_pkg;

    localparam int c_DATA_W = 8;

    // Bits needed to hold values 0..n-1; never returns less than 1.
    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_data_reg.sv
// ============================================================================
// Module   : rx_data_reg
// Brief    : Receive holding register / first-word-fall-through queue with
//            sticky overrun flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_data_reg
    import rx_data_reg_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = 1
) (
    input  logic                          i_Pclk,
    input  logic                          i_Reset,
    input  logic                          i_Push,
    input  logic                          i_Pop,
    input  logic [DATA_W-1:0]             i_Data,
    output logic [DATA_W-1:0]             o_Data,
    output logic                          o_Full,
    output logic                          o_Empty,
    output logic                          o_Overrun,
    output logic [f_clog2(DEPTH+1)-1:0]   o_Count
);

    localparam int c_PTR_W = f_clog2(DEPTH);
    localparam int c_CNT_W = f_clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overrun;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;
    logic w_drop;

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_Pop && !w_empty;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign w_do_push = i_Push && (!w_full || w_do_pop);
    assign w_drop    = i_Push && w_full && !i_Pop;

    always_ff @(posedge i_Pclk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_Data;
        end
    end

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == c_LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_do_pop) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_Data    = w_empty ? '0 : r_mem[r_rptr];
    assign o_Full    = w_full;
    assign o_Empty   = w_empty;
    assign o_Overrun = r_overrun;
    assign o_Count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rx_data_reg.sv
// ============================================================================
// Module   : tb_rx_data_reg
// Brief    : Randomised and directed bench for rx_data_reg at DEPTH=1 and 4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rx_data_reg;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] din;

    logic [7:0] d1_data;
    logic       d1_full, d1_empty, d1_ovr;
    logic [0:0] d1_cnt;
    logic [7:0] d4_data;
    logic       d4_full, d4_empty, d4_ovr;
    logic [2:0] d4_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] q1 [$];
    logic [7:0] q4 [$];
    logic       ov1, ov4;

    rx_data_reg #(.DATA_W(8), .DEPTH(1)) u_d1 (
        .i_Pclk(clk), .i_Reset(rst), .i_Push(push), .i_Pop(pop), .i_Data(din),
        .o_Data(d1_data), .o_Full(d1_full), .o_Empty(d1_empty),
        .o_Overrun(d1_ovr), .o_Count(d1_cnt)
    );

    rx_data_reg #(.DATA_W(8), .DEPTH(4)) u_d4 (
        .i_Pclk(clk), .i_Reset(rst), .i_Push(push), .i_Pop(pop), .i_Data(din),
        .o_Data(d4_data), .o_Full(d4_full), .o_Empty(d4_empty),
        .o_Overrun(d4_ovr), .o_Count(d4_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " d1.data"},  32'(d1_data),  32'(q1.size() ? q1[0] : 8'h00));
        chk({tag, " d1.full"},  32'(d1_full),  32'(q1.size() == 1));
        chk({tag, " d1.empty"}, 32'(d1_empty), 32'(q1.size() == 0));
        chk({tag, " d1.ovr"},   32'(d1_ovr),   32'(ov1));
        chk({tag, " d1.cnt"},   32'(d1_cnt),   32'(q1.size()));
        chk({tag, " d4.data"},  32'(d4_data),  32'(q4.size() ? q4[0] : 8'h00));
        chk({tag, " d4.full"},  32'(d4_full),  32'(q4.size() == 4));
        chk({tag, " d4.empty"}, 32'(d4_empty), 32'(q4.size() == 0));
        chk({tag, " d4.ovr"},   32'(d4_ovr),   32'(ov4));
        chk({tag, " d4.cnt"},   32'(d4_cnt),   32'(q4.size()));
    endtask

    // Queue semantics: a pop needs data; a push needs room, counting a same-edge pop.
    task automatic model_edge(input logic p, input logic r, input logic [7:0] d);
        bit full1, full4, pop1, pop4;
        full1 = (q1.size() == 1);
        full4 = (q4.size() == 4);
        pop1  = r && (q1.size() > 0);
        pop4  = r && (q4.size() > 0);
        if (p && full1 && !r) ov1 = 1'b1;
        else if (pop1)        ov1 = 1'b0;
        if (p && full4 && !r) ov4 = 1'b1;
        else if (pop4)        ov4 = 1'b0;
        if (pop1) void'(q1.pop_front());
        if (pop4) void'(q4.pop_front());
        if (p && (!full1 || pop1)) q1.push_back(d);
        if (p && (!full4 || pop4)) q4.push_back(d);
    endtask

    task automatic cyc(input string tag, input logic p, input logic r, input logic [7:0] d);
        push = p;
        pop  = r;
        din  = d;
        @(posedge clk);
        model_edge(p, r, d);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        q1.delete();
        q4.delete();
        ov1 = 1'b0;
        ov4 = 1'b0;
        #1;
        check_all(tag);
        push = 1'b1;
        pop  = 1'b0;
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        push = 1'b0;
        rst  = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = 8'h00;
        ov1  = 1'b0;
        ov4  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) cyc("idle", 1'b0, 1'b0, 8'h00);
        cyc("push2E", 1'b1, 1'b0, 8'h2E);
        cyc("hold1", 1'b0, 1'b0, 8'hFF);
        cyc("hold2", 1'b0, 1'b0, 8'hFF);
        cyc("pop", 1'b0, 1'b1, 8'h00);
        cyc("pop_d4", 1'b0, 1'b1, 8'h00);

        cyc("ovr_a", 1'b1, 1'b0, 8'h2E);
        cyc("ovr_b", 1'b1, 1'b0, 8'h55);
        cyc("ovr_pop", 1'b0, 1'b1, 8'h00);
        cyc("ovr_pop2", 1'b0, 1'b1, 8'h00);

        cyc("pp_a", 1'b1, 1'b0, 8'h2E);
        cyc("pp_full", 1'b1, 1'b1, 8'hA3);
        for (int i = 0; i < 3; i++) cyc("drain", 1'b0, 1'b1, 8'h00);
        cyc("pop_empty", 1'b0, 1'b1, 8'h00);
        cyc("pp_empty", 1'b1, 1'b1, 8'h11);
        async_reset("arst1");

        for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, 1'b0, 8'(i));
        cyc("pop1", 1'b0, 1'b1, 8'h00);
        cyc("pop2", 1'b0, 1'b1, 8'h00);
        cyc("push05", 1'b1, 1'b0, 8'h05);
        cyc("push06", 1'b1, 1'b0, 8'h06);
        for (int i = 0; i < 4; i++) cyc("wrap_pop", 1'b0, 1'b1, 8'h00);
        cyc("refill_a", 1'b1, 1'b0, 8'h77);
        cyc("refill_b", 1'b1, 1'b0, 8'h88);
        async_reset("arst2");

        for (int i = 0; i < 400; i++) begin
            cyc("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 40),
                8'($urandom));
        end
        async_reset("arst3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
